// File: rtl/board_io_pkg.sv
// board_io_pkg: shared types and helpers for the board I/O controller.
//   rst_state_t : board reset sequencer states (HOLD / COUNT / RUN)
//   cnt_width() : counter width for a modulus n, never less than 1 bit
package board_io_pkg;

  typedef enum logic [1:0] {
    HOLD,
    COUNT,
    RUN
  } rst_state_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/board_io_ctrl_btn_debounce.sv
// btn_debounce: one button channel.
//   Double-flop synchroniser, optional polarity inversion, then a stability
//   counter: a new level is accepted only after it has held for
//   DEBOUNCE_CYCLES consecutive cycles. Accepted 0->1 changes emit a
//   one-cycle press pulse. Cleared by reset_n only.
// Ports:
//   clk        in  system clock
//   reset_n    in  synchronous active-low reset
//   btn_raw    in  raw (asynchronous) button pin
//   btn_level  out debounced level, 1 = pressed
//   btn_press  out one-cycle pulse on accepted press
module btn_debounce
  import board_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4096,
  parameter int unsigned ACTIVE_LOW      = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1;
  logic          sync2;
  logic          s;
  logic [CW-1:0] cnt;

  assign s = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      cnt       <= '0;
      btn_level <= 1'b0;
      btn_press <= 1'b0;
    end else begin
      sync1     <= btn_raw;
      sync2     <= sync1;
      btn_press <= 1'b0;
      if (s != btn_level) begin
        if (cnt == CNT_LAST) begin
          btn_level <= s;
          btn_press <= s;
          cnt       <= '0;
        end else begin
          cnt <= cnt + CNT_ONE;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/board_io_ctrl.sv
// board_io_ctrl: board reset sequencer, N-channel button debouncer and
// M-channel LED driver.
//   Reset sequencer: sys_reset_n releases RST_CYCLES cycles after the
//   synchronised PLL lock goes high; any loss of lock restarts the count.
//   LEDs: optional PWM dimming, compiled in when BOARD_IO_PWM_EN is defined;
//   otherwise led_out follows led_on and led_duty is ignored.
// Ports:
//   clk          in  system clock (PLL output)
//   reset_n      in  synchronous active-low reset
//   pll_locked   in  PLL lock (asynchronous)
//   sys_reset_n  out registered active-low SoC reset
//   btn_raw      in  raw button pins [NUM_BTN]
//   btn_level    out debounced levels [NUM_BTN]
//   btn_press    out press pulses [NUM_BTN]
//   led_on       in  per-LED enable [NUM_LED]
//   led_duty     in  per-LED duty [NUM_LED*PWM_BITS]
//   led_out      out registered LED drive [NUM_LED]
module board_io_ctrl
  import board_io_pkg::*;
#(
  parameter int unsigned RST_CYCLES      = 256,
  parameter int unsigned NUM_BTN         = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4096,
  parameter int unsigned BTN_ACTIVE_LOW  = 0,
  parameter int unsigned NUM_LED         = 2,
  parameter int unsigned PWM_BITS        = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         pll_locked,
  output logic                         sys_reset_n,
  input  logic [NUM_BTN-1:0]           btn_raw,
  output logic [NUM_BTN-1:0]           btn_level,
  output logic [NUM_BTN-1:0]           btn_press,
  input  logic [NUM_LED-1:0]           led_on,
  input  logic [NUM_LED*PWM_BITS-1:0]  led_duty,
  output logic [NUM_LED-1:0]           led_out
);

  localparam int unsigned RW = cnt_width(RST_CYCLES);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [RW-1:0] RST_ONE  = RW'(1);

  // ---------------- reset sequencer ----------------
  logic          lock_s1;
  logic          lock_sync;
  rst_state_t    state;
  logic [RW-1:0] rst_cnt;
  logic          run_next;

  // Value sys_reset_n takes at the coming edge; lets led_out be gated in
  // the same cycle sys_reset_n changes instead of one cycle late.
  always_comb begin
    run_next = 1'b0;
    case (state)
      COUNT:   run_next = lock_sync && (rst_cnt == RST_LAST);
      RUN:     run_next = lock_sync;
      default: run_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lock_s1     <= 1'b0;
      lock_sync   <= 1'b0;
      state       <= HOLD;
      rst_cnt     <= '0;
      sys_reset_n <= 1'b0;
    end else begin
      lock_s1   <= pll_locked;
      lock_sync <= lock_s1;
      case (state)
        HOLD: begin
          sys_reset_n <= 1'b0;
          rst_cnt     <= '0;
          if (lock_sync) state <= COUNT;
        end
        COUNT: begin
          if (!lock_sync) begin
            state       <= HOLD;
            rst_cnt     <= '0;
            sys_reset_n <= 1'b0;
          end else if (rst_cnt == RST_LAST) begin
            state       <= RUN;
            sys_reset_n <= 1'b1;
          end else begin
            rst_cnt     <= rst_cnt + RST_ONE;
            sys_reset_n <= 1'b0;
          end
        end
        RUN: begin
          if (!lock_sync) begin
            state       <= HOLD;
            rst_cnt     <= '0;
            sys_reset_n <= 1'b0;
          end else begin
            sys_reset_n <= 1'b1;
          end
        end
        default: begin
          state       <= HOLD;
          rst_cnt     <= '0;
          sys_reset_n <= 1'b0;
        end
      endcase
    end
  end

  // ---------------- buttons ----------------
  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (BTN_ACTIVE_LOW)
    ) u_debounce (
      .clk       (clk),
      .reset_n   (reset_n),
      .btn_raw   (btn_raw[g]),
      .btn_level (btn_level[g]),
      .btn_press (btn_press[g])
    );
  end

  // ---------------- LEDs ----------------
  logic [NUM_LED-1:0] led_nxt;

`ifdef BOARD_IO_PWM_EN
  localparam logic [PWM_BITS-1:0] PWM_ONE = PWM_BITS'(1);

  logic [PWM_BITS-1:0] pwm_cnt;

  // Free-running; deliberately not held by sys_reset_n.
  always_ff @(posedge clk) begin
    if (!reset_n) pwm_cnt <= '0;
    else          pwm_cnt <= pwm_cnt + PWM_ONE;
  end

  always_comb begin
    led_nxt = '0;
    for (int unsigned i = 0; i < NUM_LED; i++) begin
      led_nxt[i] = led_on[i] &
                   ((led_duty[i*PWM_BITS +: PWM_BITS] == '1) ||
                    (pwm_cnt < led_duty[i*PWM_BITS +: PWM_BITS]));
    end
  end
`else
  logic unused_led_duty;
  assign unused_led_duty = ^led_duty;

  always_comb begin
    led_nxt = led_on;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n)       led_out <= '0;
    else if (!run_next) led_out <= '0;
    else                led_out <= led_nxt;
  end

endmodule
